// File: rtl/spi_bus_bridge.sv
// SPI mode-0 slave that masters a parallel register/RAM bus.
// Frames are CMD, ADDRH, ADDRL, DATA...; reads prefetch one byte ahead of the host.
module spi_bus_bridge #(
    parameter int STROBE_CYCLES = 2,
    parameter int SYNC_STAGES   = 2
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        SClk,
    input  logic        MOSI,
    input  logic        nCS,
    output logic        MISO,
    output logic        BusClock,
    output logic [15:0] Address,
    output logic [7:0]  DataOut,
    input  logic [7:0]  DataIn,
    output logic        DataOE,
    output logic        ReadWrite,
    output logic        Busy
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_ADDRH = 3'd2;
    localparam logic [2:0] ST_ADDRL = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;

    localparam int              CW          = $clog2(2 * STROBE_CYCLES + 1);
    localparam logic [CW-1:0]   STB_HI_LAST = CW'(STROBE_CYCLES);
    localparam logic [CW-1:0]   STB_LAST    = CW'(2 * STROBE_CYCLES);

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_ncs_sync;
    logic                   r_sclk_prev, r_ncs_prev;

    logic [2:0]    r_state;
    logic          r_frame_rw, r_frame_inc;
    logic [7:0]    r_rx, r_tx;
    logic [2:0]    r_bit_cnt;

    logic          r_pend, r_pend_rw, r_pend_pre_inc, r_pend_post_inc;
    logic [7:0]    r_pend_data;

    logic          r_busy, r_bus_clk, r_oe, r_rw_out, r_stb_post_inc;
    logic [CW-1:0] r_stb_cnt;
    logic [7:0]    r_dout;
    logic [15:0]   r_addr;

    logic       w_sclk, w_mosi, w_ncs;
    logic       w_sclk_rise, w_sclk_fall, w_ncs_rise, w_ncs_fall;
    logic       w_in_frame, w_bit_rise, w_byte_done, w_frame_start;
    logic [7:0] w_byte;
    logic       w_stb_start, w_stb_end, w_rd_load;

    // Chip select resets to its inactive level so a reset never fakes a frame start.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_ncs_sync  <= '1;
            r_sclk_prev <= 1'b0;
            r_ncs_prev  <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SClk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], nCS};
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
            r_ncs_prev  <= r_ncs_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk        = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi        = r_mosi_sync[SYNC_STAGES-1];
    assign w_ncs         = r_ncs_sync[SYNC_STAGES-1];
    assign w_sclk_rise   = w_sclk & ~r_sclk_prev;
    assign w_sclk_fall   = ~w_sclk & r_sclk_prev;
    assign w_ncs_rise    = w_ncs & ~r_ncs_prev;
    assign w_ncs_fall    = ~w_ncs & r_ncs_prev;
    assign w_frame_start = w_ncs_fall && (r_state == ST_IDLE);
    assign w_in_frame    = (r_state != ST_IDLE) && !w_ncs_rise;
    assign w_bit_rise    = w_sclk_rise && w_in_frame;
    assign w_byte_done   = w_bit_rise && (r_bit_cnt == 3'd7);
    assign w_byte        = {r_rx[6:0], w_mosi};

    assign w_stb_start   = r_pend && !r_busy;
    assign w_stb_end     = r_busy && (r_stb_cnt == STB_LAST);
    assign w_rd_load     = w_stb_end && !r_rw_out && (r_state != ST_IDLE);

    // The first fall after a byte completes is not shifted: that is when the
    // prefetched byte sits in TX with its MSB already on MISO.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_rx      <= '0;
            r_tx      <= '0;
            r_bit_cnt <= '0;
        end else if (w_frame_start || w_ncs_rise) begin
            r_rx      <= '0;
            r_tx      <= '0;
            r_bit_cnt <= '0;
        end else begin
            if (w_bit_rise) begin
                r_rx      <= w_byte;
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_rd_load)
                r_tx <= DataIn;
            else if (w_sclk_fall && w_in_frame && (r_bit_cnt != 3'd0))
                r_tx <= {r_tx[6:0], 1'b0};
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state         <= ST_IDLE;
            r_frame_rw      <= 1'b0;
            r_frame_inc     <= 1'b0;
            r_pend          <= 1'b0;
            r_pend_rw       <= 1'b0;
            r_pend_pre_inc  <= 1'b0;
            r_pend_post_inc <= 1'b0;
            r_pend_data     <= '0;
        end else begin
            if (w_stb_start)
                r_pend <= 1'b0;
            if (w_ncs_rise) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE:  if (w_ncs_fall) r_state <= ST_CMD;
                    ST_CMD: begin
                        if (w_byte_done) begin
                            r_frame_rw  <= w_byte[7];
                            r_frame_inc <= w_byte[0];
                            r_state     <= ST_ADDRH;
                        end
                    end
                    ST_ADDRH: if (w_byte_done) r_state <= ST_ADDRL;
                    ST_ADDRL: begin
                        if (w_byte_done) begin
                            r_state <= ST_DATA;
                            if (!r_frame_rw) begin
                                r_pend          <= 1'b1;
                                r_pend_rw       <= 1'b0;
                                r_pend_pre_inc  <= 1'b0;
                                r_pend_post_inc <= 1'b0;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (w_byte_done) begin
                            r_pend          <= 1'b1;
                            r_pend_rw       <= r_frame_rw;
                            r_pend_data     <= w_byte;
                            r_pend_pre_inc  <= !r_frame_rw && r_frame_inc;
                            r_pend_post_inc <= r_frame_rw && r_frame_inc;
                        end
                    end
                    default:  r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Strobe: one setup cycle, STROBE_CYCLES high, STROBE_CYCLES low.
    // Reads step the address before the strobe, writes step it after.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_busy         <= 1'b0;
            r_stb_cnt      <= '0;
            r_bus_clk      <= 1'b0;
            r_oe           <= 1'b0;
            r_rw_out       <= 1'b0;
            r_stb_post_inc <= 1'b0;
            r_dout         <= '0;
            r_addr         <= '0;
        end else begin
            if (w_stb_start) begin
                r_busy         <= 1'b1;
                r_stb_cnt      <= '0;
                r_bus_clk      <= 1'b0;
                r_rw_out       <= r_pend_rw;
                r_oe           <= r_pend_rw;
                r_stb_post_inc <= r_pend_post_inc;
                if (r_pend_rw)
                    r_dout <= r_pend_data;
                if (r_pend_pre_inc)
                    r_addr <= r_addr + 16'd1;
            end else if (r_busy) begin
                if (r_stb_cnt == STB_LAST) begin
                    r_busy <= 1'b0;
                    r_oe   <= 1'b0;
                    if (r_stb_post_inc)
                        r_addr <= r_addr + 16'd1;
                end else begin
                    r_stb_cnt <= r_stb_cnt + 1'b1;
                    r_bus_clk <= (r_stb_cnt < STB_HI_LAST);
                end
            end
            if (w_byte_done && (r_state == ST_ADDRH) && !w_ncs_rise)
                r_addr[15:8] <= w_byte;
            if (w_byte_done && (r_state == ST_ADDRL) && !w_ncs_rise)
                r_addr[7:0] <= w_byte;
        end
    end

    assign MISO      = r_tx[7];
    assign BusClock  = r_bus_clk;
    assign Address   = r_addr;
    assign DataOut   = r_dout;
    assign DataOE    = r_oe;
    assign ReadWrite = r_rw_out;
    assign Busy      = r_busy;

endmodule
